// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        FINISH
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: (WIDTH+1)-bit trial subtract of the divisor
// from the shifted partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_c,
    output logic             o_qbit_c
);

    logic [WIDTH:0] w_trial;

    // A restored remainder is always below the divisor, so WIDTH bits hold it.
    assign w_trial  = i_rem - {1'b0, i_divisor};
    assign o_qbit_c = ~w_trial[WIDTH];
    assign o_rem_c  = o_qbit_c ? w_trial[WIDTH-1:0] : i_rem[WIDTH-1:0];

endmodule

// File: rtl/mips_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU with START/BUSY/DONE
// handshake; quotient goes to LO, remainder to HI.
module mips_div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED_DIV,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    input  logic             CANCEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_ZERO
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;

    assign w_dvd_neg = SIGNED_DIV & DIVIDEND[WIDTH-1];
    assign w_dvs_neg = SIGNED_DIV & DIVISOR[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -DIVIDEND : DIVIDEND;
    assign w_dvs_mag = w_dvs_neg ? -DIVISOR : DIVISOR;

    // r_quo starts as the dividend magnitude and shifts quotient bits in at
    // the bottom while dividend bits leave at the top.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (w_rem_shift),
        .i_divisor (r_dvsr),
        .o_rem_c   (w_rem_next),
        .o_qbit_c  (w_qbit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_dz      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            DIV_ZERO  <= 1'b0;
        end else if (CANCEL && (r_state != IDLE)) begin
            // Abort: results from the previous operation stay visible.
            r_state <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        BUSY    <= 1'b1;
                        r_qsign <= w_dvd_neg ^ w_dvs_neg;
                        r_rsign <= w_dvd_neg;
                        r_dvsr  <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (DIVISOR == '0) begin
                            r_dz    <= 1'b1;
                            r_quo   <= DIVIDEND;
                            r_state <= FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_quo   <= w_dvd_mag;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero leaves the raw dividend in r_quo.
                    if (r_dz) begin
                        QUOTIENT  <= '1;
                        REMAINDER <= r_quo;
                    end else begin
                        QUOTIENT  <= r_qsign ? -r_quo : r_quo;
                        REMAINDER <= r_rsign ? -r_rem : r_rem;
                    end
                    DIV_ZERO <= r_dz;
                    DONE     <= 1'b1;
                    r_state  <= FINISH;
                end
                FINISH: begin
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_div.sv
// Directed bench for mips_div: vector table of DIV/DIVU cases plus
// hand-built ignored-START, CANCEL and mid-operation reset sequences.
module tb_mips_div;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        SIGNED_DIV;
    logic [31:0] DIVIDEND;
    logic [31:0] DIVISOR;
    logic        CANCEL;
    logic        BUSY;
    logic        DONE;
    logic [31:0] QUOTIENT;
    logic [31:0] REMAINDER;
    logic        DIV_ZERO;

    int checks;
    int failures;

    mips_div #(.WIDTH(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .SIGNED_DIV (SIGNED_DIV),
        .DIVIDEND   (DIVIDEND),
        .DIVISOR    (DIVISOR),
        .CANCEL     (CANCEL),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .QUOTIENT   (QUOTIENT),
        .REMAINDER  (REMAINDER),
        .DIV_ZERO   (DIV_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launches one operation in c0 and observes c1..c45. Optional events at
    // given cycles (0 = none): a second START, CANCEL, RST. Results are taken
    // at the first DONE, or the cycle after an abort.
    task automatic run_seq(
        input  logic        sgn,
        input  logic [31:0] dvd,
        input  logic [31:0] dvs,
        input  int          start2_at,
        input  int          cancel_at,
        input  int          rst_at,
        output int          done_at,
        output int          done_cnt,
        output int          busy_cnt,
        output logic [31:0] q,
        output logic [31:0] r,
        output logic        dz,
        output logic        busy_snap
    );
        int abort_at;
        abort_at  = (cancel_at != 0) ? cancel_at : rst_at;
        done_at   = -1;
        done_cnt  = 0;
        busy_cnt  = 0;
        q         = 'x;
        r         = 'x;
        dz        = 1'bx;
        busy_snap = 1'bx;
        @(posedge CLK); #1;
        START      = 1'b1;
        SIGNED_DIV = sgn;
        DIVIDEND   = dvd;
        DIVISOR    = dvs;
        for (int k = 1; k <= 45; k++) begin
            @(posedge CLK); #1;
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    if (abort_at == 0) begin
                        q  = QUOTIENT;
                        r  = REMAINDER;
                        dz = DIV_ZERO;
                    end
                end
            end
            if (abort_at != 0 && k == abort_at + 1) begin
                q         = QUOTIENT;
                r         = REMAINDER;
                dz        = DIV_ZERO;
                busy_snap = BUSY;
            end
            START  = (k == start2_at);
            CANCEL = (k == cancel_at);
            RST    = (k == rst_at);
            if (k == start2_at) begin
                DIVIDEND = 32'd50;
                DIVISOR  = 32'd5;
            end
        end
        START  = 1'b0;
        CANCEL = 1'b0;
        RST    = 1'b0;
    endtask

    vec_t        vecs[12];
    int          done_at, done_cnt, busy_cnt;
    logic [31:0] q, r;
    logic        dz, busy_snap;
    string       tag;

    initial begin
        checks     = 0;
        failures   = 0;
        RST        = 1'b1;
        START      = 1'b0;
        CANCEL     = 1'b0;
        SIGNED_DIV = 1'b0;
        DIVIDEND   = '0;
        DIVISOR    = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34};
        vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 2};
        vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0, 34};
        vecs[8]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34};
        vecs[9]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 2};
        vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34};
        vecs[11] = '{1'b1, 32'hFFFF_FFF9,  32'd1,          32'hFFFF_FFF9,  32'd0,          1'b0, 34};

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_quo",  QUOTIENT, 32'd0);
        chk("reset_rem",  REMAINDER, 32'd0);
        chk("reset_dz",   32'(DIV_ZERO), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_seq(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, 0, 0, 0,
                    done_at, done_cnt, busy_cnt, q, r, dz, busy_snap);
            tag = $sformatf("v%0d", i);
            chk({tag, "_done_cycle"}, 32'(done_at), 32'(vecs[i].exp_lat));
            chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(vecs[i].exp_lat));
            chk({tag, "_quo"}, q, vecs[i].exp_q);
            chk({tag, "_rem"}, r, vecs[i].exp_r);
            chk({tag, "_dz"}, 32'(dz), 32'(vecs[i].exp_dz));
        end

        // START while busy is ignored: 100/7 completes, 50/5 never runs.
        run_seq(1'b0, 32'd100, 32'd7, 5, 0, 0,
                done_at, done_cnt, busy_cnt, q, r, dz, busy_snap);
        chk("ign_done_cycle", 32'(done_at), 32'd34);
        chk("ign_done_count", 32'(done_cnt), 32'd1);
        chk("ign_quo", q, 32'd14);
        chk("ign_rem", r, 32'd2);

        // CANCEL in c10: no DONE, idle in c11, previous results (14 r 2) kept.
        run_seq(1'b0, 32'd100, 32'd7, 5, 10, 0,
                done_at, done_cnt, busy_cnt, q, r, dz, busy_snap);
        chk("cancel_done_count", 32'(done_cnt), 32'd0);
        chk("cancel_busy_cycles", 32'(busy_cnt), 32'd10);
        chk("cancel_busy_c11", 32'(busy_snap), 32'd0);
        chk("cancel_quo_kept", q, 32'd14);
        chk("cancel_rem_kept", r, 32'd2);
        chk("cancel_dz_kept", 32'(dz), 32'd0);

        run_seq(1'b0, 32'd9, 32'd3, 0, 0, 0,
                done_at, done_cnt, busy_cnt, q, r, dz, busy_snap);
        chk("fresh_done_cycle", 32'(done_at), 32'd34);
        chk("fresh_quo", q, 32'd3);
        chk("fresh_rem", r, 32'd0);

        // Reset in c20: clears outputs, no DONE afterwards.
        run_seq(1'b0, 32'd100, 32'd7, 0, 0, 20,
                done_at, done_cnt, busy_cnt, q, r, dz, busy_snap);
        chk("rst_done_count", 32'(done_cnt), 32'd0);
        chk("rst_busy_cycles", 32'(busy_cnt), 32'd20);
        chk("rst_busy_c21", 32'(busy_snap), 32'd0);
        chk("rst_quo", q, 32'd0);
        chk("rst_rem", r, 32'd0);

        // START together with CANCEL in IDLE is accepted.
        @(posedge CLK); #1;
        CANCEL = 1'b1;
        run_seq(1'b0, 32'd9, 32'd2, 0, 0, 0,
                done_at, done_cnt, busy_cnt, q, r, dz, busy_snap);
        chk("startcancel_done_cycle", 32'(done_at), 32'd34);
        chk("startcancel_quo", q, 32'd4);
        chk("startcancel_rem", r, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
